// File: rtl/digit_scan_ctrl.sv
// Digit scan controller: steps a 3-bit mux select at a programmable slot rate,
// drives active-low digit enables, and feeds double-buffered digit values.
module digit_scan_ctrl #(
    parameter int unsigned DIV = 100000,
    parameter int unsigned CW  = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        wr_valid,
    input  logic [2:0]  wr_addr,
    input  logic [3:0]  wr_data,
    output logic        wr_ready,
    input  logic        commit,
    output logic        commit_pending,
    output logic [2:0]  addr,
    output logic [3:0]  din0,
    output logic [3:0]  din1,
    output logic [3:0]  din2,
    output logic [3:0]  din3,
    output logic [3:0]  din4,
    output logic [3:0]  din5,
    output logic [3:0]  din6,
    output logic [3:0]  din7,
    output logic [7:0]  digit_an,
    output logic        scan_tick,
    output logic        frame_start
);

    // state    | meaning
    // CM_IDLE  | active bank is current; shadow writes accepted
    // CM_PEND  | commit requested; waits for frame wrap (or en=0) to copy
    typedef enum logic {
        CM_IDLE = 1'b0,
        CM_PEND = 1'b1
    } cm_state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    cm_state_t   state;
    cm_state_t   state_nxt;
    logic [CW-1:0] cnt;
    logic        tick;
    logic        wrap;
    logic        apply;
    logic        wr_accept;
    logic [2:0]  addr_next;
    logic [3:0]  shadow [8];
    logic [3:0]  active [8];

    assign tick      = en && (cnt == CNT_LAST);
    assign wrap      = tick && (addr == 3'd7);
    assign addr_next = tick ? addr + 3'd1 : addr;

    assign commit_pending = (state == CM_PEND);
    assign wr_ready       = ~commit_pending;
    assign wr_accept      = wr_valid && wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            addr        <= 3'd0;
            scan_tick   <= 1'b0;
            frame_start <= 1'b0;
            digit_an    <= 8'hFF;
        end else if (en) begin
            cnt         <= tick ? '0 : cnt + CW'(1);
            addr        <= addr_next;
            scan_tick   <= tick;
            frame_start <= wrap;
            digit_an    <= ~(8'b1 << addr_next);
        end else begin
            // disabled: blank the display but keep the position for re-enable
            cnt         <= '0;
            scan_tick   <= 1'b0;
            frame_start <= 1'b0;
            digit_an    <= 8'hFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        apply     = 1'b0;
        case (state)
            CM_IDLE: begin
                if (commit) begin
                    state_nxt = CM_PEND;
                end
            end
            CM_PEND: begin
                if (!en || wrap) begin
                    apply     = 1'b1;
                    state_nxt = CM_IDLE;
                end
            end
            default: state_nxt = CM_IDLE;
        endcase
    end

    // A write on the commit-request edge lands in shadow before any later copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 4'h0;
                active[i] <= 4'h0;
            end
        end else begin
            if (wr_accept) begin
                shadow[wr_addr] <= wr_data;
            end
            if (apply) begin
                active <= shadow;
            end
        end
    end

    assign din0 = active[0];
    assign din1 = active[1];
    assign din2 = active[2];
    assign din3 = active[3];
    assign din4 = active[4];
    assign din5 = active[5];
    assign din6 = active[6];
    assign din7 = active[7];

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: reference model derives position from
// elapsed enabled cycles; a negedge monitor compares against queued expectations.
module tb_digit_scan_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       wr_valid = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [3:0] wr_data = 4'h0;
    logic       commit = 1'b0;
    logic       wr_ready;
    logic       commit_pending;
    logic [2:0] addr;
    logic [3:0] din0, din1, din2, din3, din4, din5, din6, din7;
    logic [7:0] digit_an;
    logic       scan_tick;
    logic       frame_start;

    digit_scan_ctrl #(.DIV(DIV), .CW(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .commit         (commit),
        .commit_pending (commit_pending),
        .addr           (addr),
        .din0           (din0),
        .din1           (din1),
        .din2           (din2),
        .din3           (din3),
        .din4           (din4),
        .din5           (din5),
        .din6           (din6),
        .din7           (din7),
        .digit_an       (digit_an),
        .scan_tick      (scan_tick),
        .frame_start    (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  addr;
        logic [7:0]  an;
        logic        tick;
        logic        frame;
        logic        pend;
        logic        ready;
        logic [31:0] din;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_on = 1'b0;

    // reference model: position = base + (enabled cycles since enable) / DIV
    int        run;
    int        base_addr;
    int        m_addr;
    logic [3:0] m_sh [8];
    logic [3:0] m_act [8];
    bit        m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_din();
        return {din7, din6, din5, din4, din3, din2, din1, din0};
    endfunction

    task automatic model_reset();
        run = 0;
        base_addr = 0;
        m_addr = 0;
        m_pend = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_sh[i] = 4'h0;
            m_act[i] = 4'h0;
        end
    endtask

    task automatic model_step();
        bit   tk;
        bit   fr;
        bit   acc;
        bit   apl;
        int   new_addr;
        logic [7:0] one;
        exp_t e;
        tk = 1'b0;
        fr = 1'b0;
        one = 8'h01;
        acc = wr_valid && !m_pend;
        if (en) begin
            run++;
            new_addr = (base_addr + run / DIV) % 8;
            tk = (run % DIV) == 0;
            fr = tk && (new_addr == 0);
        end else begin
            run = 0;
            base_addr = m_addr;
            new_addr = m_addr;
        end
        apl = m_pend && (!en || fr);
        if (acc) m_sh[wr_addr] = wr_data;
        if (apl) begin
            for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
            m_pend = 1'b0;
        end else if (commit && !m_pend) begin
            m_pend = 1'b1;
        end
        m_addr = new_addr;
        e.addr  = 3'(m_addr);
        e.an    = en ? ~(one << m_addr) : 8'hFF;
        e.tick  = tk;
        e.frame = fr;
        e.pend  = m_pend;
        e.ready = !m_pend;
        e.din   = {m_act[7], m_act[6], m_act[5], m_act[4], m_act[3], m_act[2], m_act[1], m_act[0]};
        sbq.push_back(e);
        mon_on = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty at %0t: got no entry expected one", $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("addr", 32'(addr), 32'(e.addr));
                chk("digit_an", 32'(digit_an), 32'(e.an));
                chk("scan_tick", 32'(scan_tick), 32'(e.tick));
                chk("frame_start", 32'(frame_start), 32'(e.frame));
                chk("commit_pending", 32'(commit_pending), 32'(e.pend));
                chk("wr_ready", 32'(wr_ready), 32'(e.ready));
                chk("din", dut_din(), e.din);
            end
        end
    end

    task automatic drive(input bit e, input bit wv, input logic [2:0] wa, input logic [3:0] wd, input bit cm);
        en = e;
        wr_valid = wv;
        wr_addr = wa;
        wr_data = wd;
        commit = cm;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_addr"}, 32'(addr), 32'd0);
        chk({tag, "_digit_an"}, 32'(digit_an), 32'hFF);
        chk({tag, "_scan_tick"}, 32'(scan_tick), 32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, "_commit_pending"}, 32'(commit_pending), 32'd0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        chk({tag, "_din"}, dut_din(), 32'd0);
    endtask

    initial begin
        int guard;
        model_reset();
        #12;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // free run across more than one frame
        repeat (40) drive(1, 0, 3'd0, 4'h0, 0);

        // write two digits, commit at addr 2, wait for the frame wrap
        drive(1, 1, 3'd3, 4'hA, 0);
        drive(1, 1, 3'd7, 4'h5, 0);
        guard = 0;
        while (m_addr != 2 && guard < 64) begin
            drive(1, 0, 3'd0, 4'h0, 0);
            guard++;
        end
        drive(1, 0, 3'd0, 4'h0, 1);
        repeat (36) drive(1, 0, 3'd0, 4'h0, 0);

        // held write blocked while pending, accepted after apply
        drive(1, 0, 3'd0, 4'h0, 1);
        repeat (40) drive(1, 1, 3'd0, 4'hF, 0);
        repeat (4) drive(1, 0, 3'd0, 4'h0, 0);

        // disabled: commit applies one cycle after the request
        drive(0, 1, 3'd1, 4'h9, 0);
        drive(0, 0, 3'd0, 4'h0, 1);
        repeat (4) drive(0, 0, 3'd0, 4'h0, 0);

        // drop en at addr 5 / slot phase 2, then resume
        guard = 0;
        while (!(m_addr == 5 && run % DIV == 2) && guard < 64) begin
            drive(1, 0, 3'd0, 4'h0, 0);
            guard++;
        end
        repeat (10) drive(0, 0, 3'd0, 4'h0, 0);
        repeat (10) drive(1, 0, 3'd0, 4'h0, 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom % 8) != 0, ($urandom % 3) == 0, 3'($urandom), 4'($urandom),
                  ($urandom % 12) == 0);
        end

        // reset mid-frame with a commit pending
        repeat (8) drive(1, 0, 3'd0, 4'h0, 0);
        drive(1, 1, 3'd4, 4'hC, 1);
        drive(1, 0, 3'd0, 4'h0, 0);
        chk("pend_before_rst", 32'(commit_pending), 32'd1);
        #2;
        mon_on = 1'b0;
        sbq.delete();
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) drive(1, 0, 3'd0, 4'h0, 0);

        @(negedge clk);
        mon_on = 1'b0;
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Upstream feeder for the 8-way 4-bit digit multiplexer. Holds eight 4-bit digit values and drives them on din0..din7.
- Steps the 3-bit select address through 0..7 at a programmable rate and drives matching active-low one-hot digit enables for a multiplexed 7-segment display.
- Digit values are double-buffered. Software writes a shadow bank; a commit copies the shadow bank to the active bank only at a frame boundary, so a displayed frame never tears.

Parameters:
- DIV, 100000, clk cycles per digit slot; legal range 2..2^24-1.
- CW, 24, prescaler counter width; must satisfy 2^CW > DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable.
- wr_valid  in  1  shadow write request.
- wr_addr  in  3  shadow digit index.
- wr_data  in  4  shadow digit value.
- wr_ready  out  1  shadow write accepted when high with wr_valid.
- commit  in  1  request shadow->active copy (pulse or level).
- commit_pending  out  1  commit requested, not yet applied.
- addr  out  3  mux select, current digit.
- din0..din7  out  4 each  active-bank digit values.
- digit_an  out  8  active-low one-hot digit enable.
- scan_tick  out  1  one-cycle pulse, addr just advanced.
- frame_start  out  1  one-cycle pulse, addr just wrapped 7->0.

Behaviour:
- Reset (async assert, sync release): cnt=0, addr=0, shadow and active banks all 4'h0, digit_an=8'hFF, scan_tick=0, frame_start=0, commit_pending=0. Outputs are valid during reset; wr_ready reads 1.
- Prescaler: with en=1, cnt increments each clk. When cnt==DIV-1, cnt<=0 and a tick occurs on that edge:
  - addr<=addr+1, wrapping 7->0.
  - scan_tick<=1 for exactly one cycle, coincident with the new addr.
  - frame_start<=1 only when the tick wraps addr 7->0.
- Digit slot length is exactly DIV cycles; one frame is 8*DIV cycles.
- en=0: cnt<=0, addr holds, digit_an<=8'hFF, no ticks. On re-enable, digit_an shows the held addr on the next edge and the first tick occurs DIV cycles after en rises.
- digit_an is registered: digit_an<=~(8'b1<<addr_next) when en=1. Exactly one bit is low and it always matches addr.
- Shadow write: accepted on an edge with wr_valid && wr_ready; shadow[wr_addr]<=wr_data. wr_ready=~commit_pending (combinational). Writes while commit_pending=1 are dropped; the writer must hold wr_valid.
- Commit:
  - commit=1 with commit_pending=0 sets commit_pending<=1.
  - commit while already pending is ignored.
  - A write accepted on the same edge that commit is sampled is included in the commit.
- Commit apply, en=1: on the frame-wrap tick edge (addr 7->0) with commit_pending=1: active<=shadow, commit_pending<=0. New values appear on din* in the same cycle that frame_start=1.
- Commit apply, en=0: applied on the first edge where commit_pending=1, i.e. one cycle after the commit request.
- Commit pending when en falls: applied on the next edge.
- din0..din7 change only at reset or on a commit-apply edge, never mid-frame while en=1.
- Reset mid-operation: everything returns to reset values immediately, including loss of a pending commit and all shadow contents.

Test Plan:
- All tests use DIV=4.
- Reset, then en=1 for 40 cycles -> addr goes 0,1,2..7,0 with each value held 4 cycles; digit_an follows 8'hFE, 8'hFD, ..., 8'h7F; scan_tick pulses every 4 cycles; frame_start pulses once every 32 cycles, aligned with addr=0.
- en=1. Write shadow[3]=4'hA and shadow[7]=4'h5, pulse commit when addr=2 -> commit_pending=1 and wr_ready=0 until the next frame_start. din3 becomes 4'hA and din7 becomes 4'h5 exactly in the frame_start cycle; all other din*=0.
- With commit_pending=1, assert wr_valid wr_addr=0 wr_data=4'hF -> write not accepted while pending. After the commit applies, the held write is accepted; din0 stays 0 until the following commit.
- en=0. Write shadow[1]=4'h9 and pulse commit -> din1=4'h9 one cycle after commit; digit_an=8'hFF; addr holds.
- Drop en at addr=5 with cnt=2, hold 10 cycles, then raise -> addr stays 5; digit_an=8'hDF one edge after en rises; the next tick (addr->6) occurs exactly 4 cycles after en rises.
- Assert rst_n=0 mid-frame with commit pending -> all outputs return to reset values asynchronously; after release, commit_pending=0 and din*=0.
